// File: rtl/rv_pkg.sv
// Shared definitions for the fetch stage: word width, the NOP encoding and the
// fetch state encoding.
package rv_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ     = 3'd1,
        DISCARD = 3'd2,
        HOLD    = 3'd3,
        HALT    = 3'd4
    } fetch_state_e;

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Wait counter for the memory handshake. Clear wins over enable. expired is
// high in the cycle whose increment would reach LIMIT.
module fetch_timeout_ctr #(
    parameter int TMO_W = 8,
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [TMO_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign expired = enable && (count == TMO_W'(LIMIT - 1));

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: one outstanding imem request at a time, result held for decode
// under valid/ready, sequential PC advance via pc_en, redirect via pc_src.
module instr_fetch #(
    parameter logic [31:0] NOP_INSTR   = 32'h0000_0013,
    parameter int          ACK_TIMEOUT = 255,
    parameter int          TMO_W       = 8
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [31:0] current_pc,
    input  logic        pc_src,
    output logic        pc_en,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        id_ready,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        misaligned,
    output logic        bus_err,
    output logic [2:0]  fsm_state
);

    import rv_pkg::*;

    // Handshakes: imem_req stays high with a stable imem_addr until the cycle
    // imem_ack is seen; a decode transfer happens on any cycle with
    // if_valid & id_ready, and if_* hold steady until then.

    fetch_state_e state;
    logic         launch;
    logic         mis_pend;
    logic         tmo_clear;
    logic         tmo_en;
    logic         tmo_expired;

    // The first REQ cycle only samples current_pc, so a PC that advances or
    // redirects on the edge that entered REQ is the one that gets fetched.
    assign tmo_clear = (state == REQ) && launch;
    assign tmo_en    = imem_req && !imem_ack;
    assign fsm_state = state;

    fetch_timeout_ctr #(
        .TMO_W (TMO_W),
        .LIMIT (ACK_TIMEOUT)
    ) u_tmo (
        .clk     (sys_clk),
        .rst     (sys_rst),
        .clear   (tmo_clear),
        .enable  (tmo_en),
        .expired (tmo_expired)
    );

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state      <= IDLE;
            launch     <= 1'b0;
            mis_pend   <= 1'b0;
            imem_req   <= 1'b0;
            imem_addr  <= '0;
            pc_en      <= 1'b0;
            if_valid   <= 1'b0;
            if_instr   <= NOP_INSTR;
            if_pc      <= '0;
            misaligned <= 1'b0;
            bus_err    <= 1'b0;
        end else begin
            pc_en <= 1'b0;
            case (state)
                IDLE: begin
                    state  <= REQ;
                    launch <= 1'b1;
                end
                REQ: begin
                    if (launch) begin
                        if (!pc_src) begin
                            launch    <= 1'b0;
                            imem_addr <= current_pc;
                            if (current_pc[1:0] != 2'b00) begin
                                mis_pend <= 1'b1;
                            end else begin
                                imem_req <= 1'b1;
                            end
                        end
                    end else if (mis_pend) begin
                        mis_pend <= 1'b0;
                        if (pc_src) begin
                            launch <= 1'b1;
                        end else begin
                            if_valid   <= 1'b1;
                            misaligned <= 1'b1;
                            if_instr   <= NOP_INSTR;
                            if_pc      <= imem_addr;
                            state      <= HOLD;
                        end
                    end else if (imem_ack) begin
                        imem_req <= 1'b0;
                        if (pc_src) begin
                            launch <= 1'b1;
                        end else begin
                            if_valid <= 1'b1;
                            if_instr <= imem_rdata;
                            if_pc    <= imem_addr;
                            pc_en    <= 1'b1;
                            state    <= HOLD;
                        end
                    end else if (tmo_expired) begin
                        bus_err  <= 1'b1;
                        imem_req <= 1'b0;
                        state    <= HALT;
                    end else if (pc_src) begin
                        state <= DISCARD;
                    end
                end
                DISCARD: begin
                    if (imem_ack) begin
                        imem_req <= 1'b0;
                        state    <= REQ;
                        launch   <= 1'b1;
                    end else if (tmo_expired) begin
                        bus_err  <= 1'b1;
                        imem_req <= 1'b0;
                        state    <= HALT;
                    end
                end
                HOLD: begin
                    if (pc_src || id_ready) begin
                        if_valid   <= 1'b0;
                        misaligned <= 1'b0;
                        if_instr   <= NOP_INSTR;
                        state      <= REQ;
                        launch     <= 1'b1;
                    end
                end
                HALT: begin
                    imem_req <= 1'b0;
                    if_valid <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a small PC register model in the loop;
// expected values are hand-computed per scenario.
module tb_instr_fetch;

    import rv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_q;
    logic [31:0] pc_target;
    logic        pc_src;
    logic        pc_en;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        id_ready;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        misaligned;
    logic        bus_err;
    logic [2:0]  fsm_state;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // PC register: redirect has priority over sequential advance.
    always @(posedge clk) begin
        if (rst)         pc_q <= 32'h0;
        else if (pc_src) pc_q <= pc_target;
        else if (pc_en)  pc_q <= pc_q + 32'd4;
    end

    instr_fetch dut (
        .sys_clk    (clk),
        .sys_rst    (rst),
        .current_pc (pc_q),
        .pc_src     (pc_src),
        .pc_en      (pc_en),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .id_ready   (id_ready),
        .if_valid   (if_valid),
        .if_instr   (if_instr),
        .if_pc      (if_pc),
        .misaligned (misaligned),
        .bus_err    (bus_err),
        .fsm_state  (fsm_state)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    initial begin
        rst = 1'b1; pc_src = 1'b0; pc_target = '0;
        imem_ack = 1'b0; imem_rdata = '0; id_ready = 1'b0;
        step(); step();

        // reset state
        check("rst_state", 32'(fsm_state), 32'(IDLE));
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_pc_en", 32'(pc_en), 32'd0);
        check("rst_valid", 32'(if_valid), 32'd0);
        check("rst_instr", if_instr, 32'h0000_0013);
        check("rst_ifpc", if_pc, 32'h0);
        check("rst_mis", 32'(misaligned), 32'd0);
        check("rst_berr", 32'(bus_err), 32'd0);

        // basic 1-cycle memory fetch at 0x0
        rst = 1'b0;
        step();
        check("idle_noreq", 32'(imem_req), 32'd0);
        step();
        check("f0_req", 32'(imem_req), 32'd1);
        check("f0_addr", imem_addr, 32'h0);
        imem_ack = 1'b1; imem_rdata = 32'h0050_0093;
        step();
        imem_ack = 1'b0;
        check("f0_valid", 32'(if_valid), 32'd1);
        check("f0_ifpc", if_pc, 32'h0);
        check("f0_instr", if_instr, 32'h0050_0093);
        check("f0_pc_en", 32'(pc_en), 32'd1);
        check("f0_req_low", 32'(imem_req), 32'd0);

        // decode stalls 5 cycles
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_valid", 32'(if_valid), 32'd1);
            check("stall_instr", if_instr, 32'h0050_0093);
            check("stall_ifpc", if_pc, 32'h0);
            check("stall_noreq", 32'(imem_req), 32'd0);
            check("stall_no_pc_en", 32'(pc_en), 32'd0);
        end
        id_ready = 1'b1;
        step();
        id_ready = 1'b0;
        check("hs_valid_drop", 32'(if_valid), 32'd0);
        check("hs_instr_nop", if_instr, 32'h0000_0013);
        step();
        check("f1_req", 32'(imem_req), 32'd1);
        check("f1_addr", imem_addr, 32'h4);

        // redirect while waiting for ack
        step();
        check("wait_req", 32'(imem_req), 32'd1);
        pc_src = 1'b1; pc_target = 32'h3E8;
        step();
        pc_src = 1'b0;
        check("disc_state", 32'(fsm_state), 32'(DISCARD));
        check("disc_req_kept", 32'(imem_req), 32'd1);
        check("disc_addr_kept", imem_addr, 32'h4);
        step();
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        step();
        imem_ack = 1'b0;
        check("disc_no_valid", 32'(if_valid), 32'd0);
        check("disc_no_pc_en", 32'(pc_en), 32'd0);
        check("disc_req_low", 32'(imem_req), 32'd0);
        step();
        check("f2_req", 32'(imem_req), 32'd1);
        check("f2_addr", imem_addr, 32'h3E8);

        // redirect in HOLD with id_ready in the same cycle
        imem_ack = 1'b1; imem_rdata = 32'h00A0_0113;
        step();
        imem_ack = 1'b0;
        check("f2_valid", 32'(if_valid), 32'd1);
        check("f2_ifpc", if_pc, 32'h3E8);
        check("f2_instr", if_instr, 32'h00A0_0113);
        pc_src = 1'b1; pc_target = 32'h2000; id_ready = 1'b1;
        step();
        pc_src = 1'b0; id_ready = 1'b0;
        check("flush_valid", 32'(if_valid), 32'd0);
        check("flush_instr", if_instr, 32'h0000_0013);
        step();
        check("f3_req", 32'(imem_req), 32'd1);
        check("f3_addr", imem_addr, 32'h2000);

        // redirect to a misaligned address
        imem_ack = 1'b1; imem_rdata = 32'h1111_1111;
        step();
        imem_ack = 1'b0;
        pc_src = 1'b1; pc_target = 32'h1002;
        step();
        pc_src = 1'b0;
        step();
        check("mis_noreq", 32'(imem_req), 32'd0);
        step();
        check("mis_valid", 32'(if_valid), 32'd1);
        check("mis_flag", 32'(misaligned), 32'd1);
        check("mis_instr", if_instr, 32'h0000_0013);
        check("mis_ifpc", if_pc, 32'h1002);
        check("mis_no_pc_en", 32'(pc_en), 32'd0);
        check("mis_noreq2", 32'(imem_req), 32'd0);
        step();
        check("mis_hold", 32'(misaligned), 32'd1);
        id_ready = 1'b1; pc_src = 1'b1; pc_target = 32'h100;
        step();
        id_ready = 1'b0; pc_src = 1'b0;
        check("mis_clear", 32'(misaligned), 32'd0);
        check("mis_valid_drop", 32'(if_valid), 32'd0);
        step();
        check("f4_req", 32'(imem_req), 32'd1);
        check("f4_addr", imem_addr, 32'h100);

        // ack never arrives: timeout
        for (int i = 1; i <= 255; i++) begin
            step();
            if (i == 254) begin
                check("tmo_early_berr", 32'(bus_err), 32'd0);
                check("tmo_early_req", 32'(imem_req), 32'd1);
            end
        end
        check("tmo_berr", 32'(bus_err), 32'd1);
        check("tmo_req_drop", 32'(imem_req), 32'd0);
        check("tmo_halt", 32'(fsm_state), 32'(HALT));
        id_ready = 1'b1; imem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("halt_berr", 32'(bus_err), 32'd1);
            check("halt_req", 32'(imem_req), 32'd0);
            check("halt_valid", 32'(if_valid), 32'd0);
            check("halt_state", 32'(fsm_state), 32'(HALT));
        end
        id_ready = 1'b0; imem_ack = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rerst_berr", 32'(bus_err), 32'd0);
        check("rerst_state", 32'(fsm_state), 32'(IDLE));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
